// File: rtl/conv_pkg.sv
// Shared types for the conv window datapath: kernel size, signed pixel, 5x5 window.
// No logic; imported by the window generator and its line buffers.
// window_t is indexed [row][col] with row 0 the oldest image row.
package conv_pkg;
    localparam int KSIZE = 5;
    typedef logic signed [7:0] pix_t;
    typedef pix_t window_t [KSIZE-1:0][KSIZE-1:0];
endpackage

// File: rtl/conv_line_buffer.sv
// One image-row delay: a DEPTH-entry pixel store addressed by column.
// Latency: dout is combinational from addr (read-before-write), so it returns the previous row's pixel.
// Backpressure: none internally; writes only when en is high, so stalls simply freeze contents.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 28,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  pix_t          din,
    output pix_t          dout
);

    // Storage is deliberately unreset: stale rows are never windowed.
    pix_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[addr] <= din;
        end
    end

    assign dout = mem_q[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 sliding-window generator over a raster pixel stream; CONV_WIN_POS_EN adds win_row/win_col.
// Latency: a window appears one cycle after the pixel that completes it is accepted.
// Backpressure: single output register; pix_ready = !win_valid || win_ready, window frozen while stalled.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic    clk,
    input  logic    rst_n,
    input  pix_t    pix_in,
    input  logic    pix_valid,
    input  logic    pix_sof,
    output logic    pix_ready,
    output window_t window,
    output logic    win_valid,
    input  logic    win_ready,
    output logic    frame_done
`ifdef CONV_WIN_POS_EN
    ,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_K    = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(KSIZE - 1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          acc, emit, last_pos;
    window_t       win_q, win_d;
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;
    pix_t          lb_din  [KSIZE-1];
    pix_t          lb_dout [KSIZE-1];

    assign pix_ready = !win_valid_q || win_ready;

    // sof pins the accepted pixel to (0,0) regardless of where the counters were.
    always_comb begin
        acc      = pix_valid && pix_ready;
        cur_col  = pix_sof ? '0 : col_q;
        cur_row  = pix_sof ? '0 : row_q;
        emit     = (cur_row >= ROW_K) && (cur_col >= COL_K);
        last_pos = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end

    always_comb begin
        lb_din[0] = pix_in;
        for (int k = 1; k < KSIZE - 1; k++) begin
            lb_din[k] = lb_dout[k-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < KSIZE - 1; g++) begin : g_lb
            conv_line_buffer #(.DEPTH(IMG_W)) u_lb (
                .clk  (clk),
                .en   (acc),
                .addr (cur_col),
                .din  (lb_din[g]),
                .dout (lb_dout[g])
            );
        end
    endgenerate

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        frame_done_d = frame_done_q;
        if (acc) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
            end
            // Deepest line buffer holds the oldest row, which lands in window row 0.
            for (int i = 0; i < KSIZE - 1; i++) begin
                win_d[i][KSIZE-1] = lb_dout[KSIZE-2-i];
            end
            win_d[KSIZE-1][KSIZE-1] = pix_in;
            win_valid_d  = emit;
            frame_done_d = emit && last_pos;
        end else if (win_ready) begin
            win_valid_d  = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: '0};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign window     = win_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

`ifdef CONV_WIN_POS_EN
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;

    always_comb begin
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        if (acc && emit) begin
            win_row_d = cur_row - ROW_K;
            win_col_d = cur_col - COL_K;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
        end
    end

    assign win_row = win_row_q;
    assign win_col = win_col_q;
`endif

endmodule
